// File: rtl/jt_sfg01_busmst.sv
// rtl/jt_sfg01_busmst.sv - MSX slot-3 bus initiator with wait stretching and int_n synchroniser
module jt_sfg01_busmst #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int WAIT_MAX   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        req_we,
  input  logic [13:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        ack,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic [13:0] addr,
  output logic [7:0]  dout,
  output logic        dout_oe,
  input  logic [7:0]  din,
  output logic        slt3_n,
  output logic        rd_n,
  output logic        wr_n,
  input  logic        wait_n,
  input  logic        int_n,
  output logic        irq
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, STRETCH, HOLD, DONE} state_t;

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYC - 1);
  localparam logic [7:0] WAIT_LAST   = 8'(WAIT_MAX - 1);
  localparam logic       SKIP_HOLD   = (HOLD_CYC == 0);

  state_t      state;
  logic [3:0]  cnt;
  logic [7:0]  wcnt;
  logic        we_q;
  logic        err_q;
  logic        int_s1;
  logic        int_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wcnt    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
      addr    <= '0;
      dout    <= '0;
      dout_oe <= 1'b0;
      slt3_n  <= 1'b1;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            we_q   <= req_we;
            addr   <= req_addr;
            slt3_n <= 1'b0;
            busy   <= 1'b1;
            err_q  <= 1'b0;
            cnt    <= '0;
            if (req_we) begin
              dout    <= req_wdata;
              dout_oe <= 1'b1;
            end
            state <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt <= '0;
            if (we_q) wr_n <= 1'b0;
            else      rd_n <= 1'b0;
            state <= STROBE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        STROBE, STRETCH: begin
          // Strobe ends on wait_n high after the minimum width, or on stretch timeout.
          if (state == STROBE && cnt != STROBE_LAST) begin
            cnt <= cnt + 4'd1;
          end else if (state == STROBE && !wait_n) begin
            wcnt  <= '0;
            state <= STRETCH;
          end else if (!wait_n && wcnt != WAIT_LAST) begin
            wcnt <= wcnt + 8'd1;
          end else begin
            cnt  <= '0;
            rd_n <= 1'b1;
            wr_n <= 1'b1;
            if (!wait_n)   err_q <= 1'b1;
            else if (!we_q) rdata <= din;
            if (SKIP_HOLD) begin
              slt3_n  <= 1'b1;
              dout_oe <= 1'b0;
              state   <= DONE;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            slt3_n  <= 1'b1;
            dout_oe <= 1'b0;
            state   <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          ack   <= 1'b1;
          err   <= err_q;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      int_s1 <= 1'b1;
      int_s2 <= 1'b1;
    end else begin
      int_s1 <= int_n;
      int_s2 <= int_s1;
    end
  end

  assign irq = ~int_s2;

endmodule
